// File: rtl/eei_sched.sv
//------------------------------------------------------------------------------
// Module      : eei_sched
// Description : Dispatches core EEI requests to one of four custom execution
//               unit slots and returns a one-cycle response. Optional issue
//               timeout enabled by defining SOPHON_EEI_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eei_sched #(
    parameter int NUM_UNIT = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   eei_req_i,
    input  logic                   eei_ext_i,
    input  logic [2:0]             eei_funct3_i,
    input  logic [NUM_UNIT-1:0]    unit_en_i,
    output logic                   eei_ack_o,
    output logic                   eei_error_o,
    output logic [31:0]            eei_rd_val_o,
    output logic                   busy_o,
    output logic [NUM_UNIT-1:0]    unit_req_o,
    input  logic [NUM_UNIT-1:0]    unit_ack_i,
    input  logic [NUM_UNIT-1:0]    unit_error_i,
    input  logic [NUM_UNIT*32-1:0] unit_rd_val_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx;
    logic                w_legal;
    logic                w_accept;
    logic                w_sel_ack;
    logic                w_resp_err;
    logic [31:0]         w_resp_val;
    logic [NUM_UNIT-1:0] r_unit_req;
    logic                r_err;
    logic [31:0]         r_rdval;
    logic [31:0]         w_slot [NUM_UNIT];

    for (genvar k = 0; k < NUM_UNIT; k++) begin : g_slot
        assign w_slot[k] = unit_rd_val_i[32*k +: 32];
    end

    assign w_idx     = {eei_ext_i, eei_funct3_i[0]};
    assign w_legal   = (eei_funct3_i[2:1] == 2'b00) && unit_en_i[w_idx];
    assign w_accept  = (r_state == S_IDLE) && eei_req_i && w_legal;
    assign w_sel_ack = unit_ack_i[r_idx];

`ifdef SOPHON_EEI_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_term;

    assign w_term = (r_cnt == 8'(TIMEOUT - 1));

    // Saturating count of cycles spent waiting in ISSUE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else if (w_accept) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_ISSUE && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        w_next     = r_state;
        w_resp_err = 1'b0;
        w_resp_val = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (eei_req_i) begin
                    if (w_legal) begin
                        w_next = S_ISSUE;
                    end else begin
                        w_next     = S_RESP;
                        w_resp_err = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // A unit ack takes priority over a coincident timeout
                if (w_sel_ack) begin
                    w_next     = S_RESP;
                    w_resp_err = unit_error_i[r_idx];
                    w_resp_val = w_slot[r_idx];
                end
`ifdef SOPHON_EEI_TIMEOUT_EN
                else if (w_term) begin
                    w_next     = S_RESP;
                    w_resp_err = 1'b1;
                end
`endif
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_unit_req <= '0;
            r_err      <= 1'b0;
            r_rdval    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx      <= w_idx;
                r_unit_req <= NUM_UNIT'(1) << w_idx;
            end else if (w_next != S_ISSUE) begin
                r_unit_req <= '0;
            end
            // Response fields live only for the RESP cycle
            if (w_next == S_RESP) begin
                r_err   <= w_resp_err;
                r_rdval <= w_resp_val;
            end else begin
                r_err   <= 1'b0;
                r_rdval <= 32'd0;
            end
        end
    end

    assign eei_ack_o    = (r_state == S_RESP);
    assign eei_error_o  = r_err;
    assign eei_rd_val_o = r_rdval;
    assign busy_o       = (r_state != S_IDLE);
    assign unit_req_o   = r_unit_req;

endmodule

`default_nettype wire

// File: tb/tb_eei_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_eei_sched
// Description : Directed self-checking bench for eei_sched with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_eei_sched;

    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         eei_req_i;
    logic         eei_ext_i;
    logic [2:0]   eei_funct3_i;
    logic [3:0]   unit_en_i;
    logic         eei_ack_o;
    logic         eei_error_o;
    logic [31:0]  eei_rd_val_o;
    logic         busy_o;
    logic [3:0]   unit_req_o;
    logic [3:0]   unit_ack_i;
    logic [3:0]   unit_error_i;
    logic [127:0] unit_rd_val_i;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    eei_sched #(.NUM_UNIT(4), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .eei_req_i    (eei_req_i),
        .eei_ext_i    (eei_ext_i),
        .eei_funct3_i (eei_funct3_i),
        .unit_en_i    (unit_en_i),
        .eei_ack_o    (eei_ack_o),
        .eei_error_o  (eei_error_o),
        .eei_rd_val_o (eei_rd_val_o),
        .busy_o       (busy_o),
        .unit_req_o   (unit_req_o),
        .unit_ack_i   (unit_ack_i),
        .unit_error_i (unit_error_i),
        .unit_rd_val_i(unit_rd_val_i)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction, then one pending response
    bit          m_active;
    int          m_unit;
    int          m_wait;
    bit          m_resp;
    bit          m_err;
    logic [31:0] m_val;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_active <= 1'b0; m_unit <= 0; m_wait <= 0;
            m_resp <= 1'b0; m_err <= 1'b0; m_val <= 32'd0;
        end else if (m_resp) begin
            m_resp <= 1'b0; m_err <= 1'b0; m_val <= 32'd0;
        end else if (m_active) begin
            if (unit_ack_i[m_unit]) begin
                m_active <= 1'b0; m_resp <= 1'b1;
                m_err <= unit_error_i[m_unit];
                m_val <= unit_rd_val_i[m_unit*32 +: 32];
            end
`ifdef SOPHON_EEI_TIMEOUT_EN
            else if (m_wait + 1 >= TIMEOUT) begin
                m_active <= 1'b0; m_resp <= 1'b1; m_err <= 1'b1; m_val <= 32'd0;
            end
`endif
            else begin
                m_wait <= m_wait + 1;
            end
        end else if (eei_req_i) begin
            if (eei_funct3_i[2:1] == 2'b00 && unit_en_i[{eei_ext_i, eei_funct3_i[0]}]) begin
                m_active <= 1'b1; m_wait <= 0;
                m_unit <= int'({eei_ext_i, eei_funct3_i[0]});
            end else begin
                m_resp <= 1'b1; m_err <= 1'b1; m_val <= 32'd0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_unit_req", 32'(unit_req_o), m_active ? 32'(4'b0001 << m_unit) : 32'd0);
            check("model_busy", 32'(busy_o), 32'(m_active || m_resp));
            check("model_ack", 32'(eei_ack_o), 32'(m_resp));
            check("model_error", 32'(eei_error_o), m_resp ? 32'(m_err) : 32'd0);
            check("model_rd_val", eei_rd_val_o, m_resp ? m_val : 32'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic request(input logic ext, input logic [2:0] f3);
        eei_req_i = 1'b1; eei_ext_i = ext; eei_funct3_i = f3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b1; eei_req_i = 1'b0; eei_ext_i = 1'b0; eei_funct3_i = 3'd0;
        unit_en_i = 4'b1111; unit_ack_i = 4'b0; unit_error_i = 4'b0; unit_rd_val_i = '0;
        repeat (3) tick;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_unit_req", 32'(unit_req_o), 32'd0);
        rst_i = 1'b0;
        tick;
        chk_en = 1'b1;

        // Unit 0, acks in the first ISSUE cycle
        request(1'b0, 3'd0);
        tick;
        check("t1_unit_req", 32'(unit_req_o), 32'h1);
        check("t1_no_early_ack", 32'(eei_ack_o), 32'd0);
        unit_ack_i = 4'b0001; unit_rd_val_i[31:0] = 32'hDEADBEEF;
        tick;
        unit_ack_i = 4'b0;
        check("t1_ack", 32'(eei_ack_o), 32'd1);
        check("t1_error", 32'(eei_error_o), 32'd0);
        check("t1_rd_val", eei_rd_val_o, 32'hDEADBEEF);
        eei_req_i = 1'b0;
        tick;
        check("t1_idle", 32'(busy_o), 32'd0);

        // Unit 3; a unit 2 ack is ignored, unit 3 acks with error
        unit_rd_val_i[95:64] = 32'h22222222; unit_rd_val_i[127:96] = 32'h33333333;
        request(1'b1, 3'd1);
        tick;
        check("t2_unit_req", 32'(unit_req_o), 32'h8);
        unit_ack_i = 4'b0100; unit_error_i = 4'b0100;
        tick;
        unit_ack_i = 4'b0; unit_error_i = 4'b0;
        tick;
        check("t2_still_waiting", 32'(unit_req_o), 32'h8);
        unit_ack_i = 4'b1000; unit_error_i = 4'b1000;
        tick;
        unit_ack_i = 4'b0; unit_error_i = 4'b0;
        check("t2_ack", 32'(eei_ack_o), 32'd1);
        check("t2_error", 32'(eei_error_o), 32'd1);
        check("t2_rd_val", eei_rd_val_o, 32'h33333333);
        eei_req_i = 1'b0;
        tick;

        // Illegal funct3: immediate error response
        request(1'b0, 3'b010);
        tick;
        check("t3_ack", 32'(eei_ack_o), 32'd1);
        check("t3_error", 32'(eei_error_o), 32'd1);
        check("t3_rd_val", eei_rd_val_o, 32'd0);
        check("t3_unit_req", 32'(unit_req_o), 32'd0);
        eei_req_i = 1'b0;
        tick;

        // Disabled slot 1: error response, no unit request
        unit_en_i = 4'b1101;
        request(1'b0, 3'd1);
        tick;
        check("t4_ack", 32'(eei_ack_o), 32'd1);
        check("t4_error", 32'(eei_error_o), 32'd1);
        check("t4_unit_req", 32'(unit_req_o), 32'd0);
        eei_req_i = 1'b0; unit_en_i = 4'b1111;
        tick;

        // Reset during the second ISSUE cycle, stale ack afterwards
        request(1'b1, 3'd0);
        tick;
        tick;
        check("t5_pre_reset", 32'(unit_req_o), 32'h4);
        rst_i = 1'b1; eei_req_i = 1'b0;
        #1;
        check("t5_rst_unit_req", 32'(unit_req_o), 32'd0);
        check("t5_rst_busy", 32'(busy_o), 32'd0);
        check("t5_rst_ack", 32'(eei_ack_o), 32'd0);
        tick;
        rst_i = 1'b0; unit_ack_i = 4'b0100; unit_rd_val_i[95:64] = 32'hBAD0BAD0;
        tick;
        unit_ack_i = 4'b0;
        check("t5_no_ack", 32'(eei_ack_o), 32'd0);
        check("t5_busy", 32'(busy_o), 32'd0);
        tick;

        // Back-to-back: unit 0 then unit 1
        request(1'b0, 3'd0);
        tick;
        unit_ack_i = 4'b0001; unit_rd_val_i[31:0] = 32'hA5A5A5A5;
        tick;
        unit_ack_i = 4'b0; eei_req_i = 1'b0;
        check("t6_first_ack", 32'(eei_ack_o), 32'd1);
        check("t6_req_during_resp", 32'(unit_req_o), 32'd0);
        tick;
        check("t6_idle_gap", 32'(unit_req_o), 32'd0);
        request(1'b0, 3'd1);
        tick;
        check("t6_second_req", 32'(unit_req_o), 32'h2);
        unit_ack_i = 4'b0010; unit_rd_val_i[63:32] = 32'h0000_1111;
        tick;
        unit_ack_i = 4'b0; eei_req_i = 1'b0;
        check("t6_second_rd_val", eei_rd_val_o, 32'h0000_1111);
        tick;

`ifdef SOPHON_EEI_TIMEOUT_EN
        // Unit never acks: request held exactly TIMEOUT cycles
        request(1'b0, 3'd0);
        tick;
        eei_req_i = 1'b0;
        n = 0;
        while (unit_req_o == 4'h1 && n < 100) begin
            n++;
            tick;
        end
        check("t7_req_cycles", 32'(n), 32'd16);
        check("t7_ack", 32'(eei_ack_o), 32'd1);
        check("t7_error", 32'(eei_error_o), 32'd1);
        check("t7_rd_val", eei_rd_val_o, 32'd0);
        tick;

        // Ack on the terminal-count edge wins
        request(1'b0, 3'd1);
        tick;
        eei_req_i = 1'b0;
        repeat (TIMEOUT - 1) tick;
        check("t8_still_req", 32'(unit_req_o), 32'h2);
        unit_ack_i = 4'b0010; unit_rd_val_i[63:32] = 32'h12345678;
        tick;
        unit_ack_i = 4'b0;
        check("t8_ack", 32'(eei_ack_o), 32'd1);
        check("t8_error", 32'(eei_error_o), 32'd0);
        check("t8_rd_val", eei_rd_val_o, 32'h12345678);
        tick;
`else
        // Without timeout the request waits indefinitely
        request(1'b0, 3'd0);
        tick;
        eei_req_i = 1'b0;
        n = 0;
        repeat (40) tick;
        check("t7_still_req", 32'(unit_req_o), 32'h1);
        check("t7_no_ack", 32'(eei_ack_o), 32'd0);
        unit_ack_i = 4'b0001; unit_rd_val_i[31:0] = 32'hCAFEF00D;
        tick;
        unit_ack_i = 4'b0;
        check("t7_ack", 32'(eei_ack_o), 32'd1);
        check("t7_rd_val", eei_rd_val_o, 32'hCAFEF00D);
        tick;
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/eei_sched.md
EEI_SCHED -- requirements
Module: eei_sched

Interface
REQ-001 Parameter NUM_UNIT, default 4, number of custom execution unit slots; fixed at 4 (index is 2 bits).
REQ-002 Parameter TIMEOUT, default 16, maximum cycles a unit may hold a request unacknowledged; legal range 2..255.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 eei_req_i  input  1  core request, level, held until eei_ack_o seen.
REQ-006 eei_ext_i  input  1  extended-opcode flag; unit index bit 1.
REQ-007 eei_funct3_i  input  3  bit 0 is unit index bit 0; bits 2:1 must be 0.
REQ-008 unit_en_i  input  NUM_UNIT  per-slot implemented/enabled mask.
REQ-009 eei_ack_o  output  1  one-cycle response pulse.
REQ-010 eei_error_o  output  1  error qualifier, valid with eei_ack_o.
REQ-011 eei_rd_val_o  output  32  result, valid with eei_ack_o.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 unit_req_o  output  NUM_UNIT  one-hot request to selected unit.
REQ-014 unit_ack_i  input  NUM_UNIT  per-unit completion, sampled only for the selected unit.
REQ-015 unit_error_i  input  NUM_UNIT  per-unit error, valid with unit_ack_i.
REQ-016 unit_rd_val_i  input  NUM_UNIT*32  packed per-unit results, slot k at bits 32k+31:32k.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RESP; eei_req_i SHALL be sampled only in IDLE.
REQ-018 IDLE, eei_req_i=1, funct3[2:1]=0, unit_en_i[idx]=1: latch idx, clear timeout counter, go ISSUE.
REQ-019 IDLE, eei_req_i=1 with funct3[2:1]!=0 or unit_en_i[idx]=0: go RESP with error=1, rd_val=0, no unit_req_o.
REQ-020 In ISSUE unit_req_o SHALL be one-hot at latched idx, registered, first high the cycle after the accepting edge.
REQ-021 ISSUE, unit_ack_i[idx]=1 at an edge: capture unit_error_i[idx] and slot-idx rd_val, drop unit_req_o, go RESP.
REQ-022 RESP: eei_ack_o=1 for exactly one cycle with captured error/rd_val, then IDLE unconditionally.
REQ-023 Minimum latency: request accepted at edge N, unit acks in cycle N+1, eei_ack_o high in cycle N+2.
REQ-024 Core SHALL deassert eei_req_i at the edge ending RESP; a request still high in IDLE is treated as new.
REQ-025 unit_ack_i bits of non-selected slots, and any unit_ack_i in IDLE/RESP, SHALL be ignored.
REQ-026 eei_rd_val_o and eei_error_o SHALL be 0 whenever eei_ack_o=0.
REQ-027 Timeout counter: 8 bits, increments each ISSUE cycle, saturates; unused when macro absent.

Reset
REQ-028 rst_i asserted, including mid-ISSUE: state IDLE; unit_req_o, eei_ack_o, eei_error_o, eei_rd_val_o, busy_o, counter, latched idx all 0 immediately.
REQ-029 A unit ack arriving during or after reset for an aborted request SHALL be ignored.

Configuration
REQ-030 Macro SOPHON_EEI_TIMEOUT_EN defined: ISSUE with counter = TIMEOUT-1 and no ack goes RESP, error=1, rd_val=0, unit_req_o dropped.
REQ-031 Ack and terminal count on the same edge: ack wins, unit response delivered.
REQ-032 Macro undefined: no counter logic; ISSUE waits indefinitely for unit_ack_i[idx].

Verification
REQ-033 unit_en_i=4'b1111, req ext=0 funct3=0; unit0 acks next cycle with rd_val 0xDEADBEEF -> eei_ack_o cycle N+2, error=0, rd_val=0xDEADBEEF.
REQ-034 req ext=1 funct3=1; unit2 acks (ignored), unit3 acks after 3 cycles with error=1 -> only unit_req_o=4'b1000, response error=1.
REQ-035 req funct3=3'b010 -> no unit_req_o, eei_ack_o cycle N+1, error=1, rd_val=0.
REQ-036 With SOPHON_EEI_TIMEOUT_EN, TIMEOUT=16, unit never acks -> unit_req_o high 16 cycles, then ack with error=1, rd_val=0.
REQ-037 rst_i pulsed in ISSUE cycle 2, unit acks next cycle -> all outputs 0, no eei_ack_o, busy_o=0.
REQ-038 Back-to-back requests to units 0 and 1 -> second unit_req_o starts no earlier than the cycle after first eei_ack_o.
